// File: rtl/vga_rect_fill.sv
`default_nettype none
// ============================================================================
// Module   : vga_rect_fill
// Brief    : Queued rectangle filler that streams one clipped pixel per cycle
//            to a VGA adapter. Define CLEAR_ON_RESET_EN to clear the screen to
//            12'h222 after every reset.
// Revision : 1.0
// ============================================================================
module vga_rect_fill #(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_x0,
  input  logic [6:0]  req_y0,
  input  logic [7:0]  req_w,
  input  logic [6:0]  req_h,
  input  logic [11:0] req_colour,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [11:0] colour,
  output logic        writeEn,
  output logic        busy
);

  localparam int              c_AW       = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0]   c_PTR_ONE  = (c_AW+1)'(1);
  localparam logic [8:0]      c_SCREEN_W = 9'(SCREEN_W);
  localparam logic [7:0]      c_SCREEN_H = 8'(SCREEN_H);
`ifdef CLEAR_ON_RESET_EN
  localparam logic [11:0]     c_CLEAR_COLOUR = 12'h222;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAW  = 2'd2
`ifdef CLEAR_ON_RESET_EN
    , S_CLEAR = 2'd3
`endif
  } state_t;

  state_t r_state, w_state_nxt;

  // --------------------------------------------------------------------------
  // Request FIFO (extra pointer bit distinguishes full from empty)
  // --------------------------------------------------------------------------
  logic [41:0]   r_mem [FIFO_DEPTH];
  logic [c_AW:0] r_wp;
  logic [c_AW:0] r_rp;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [41:0]   w_head;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[c_AW] != r_rp[c_AW]) &&
                   (r_wp[c_AW-1:0] == r_rp[c_AW-1:0]);

`ifdef CLEAR_ON_RESET_EN
  assign req_ready = !w_full && (r_state != S_CLEAR);
`else
  assign req_ready = !w_full;
`endif

  assign w_push = req_valid && req_ready;
  assign w_head = r_mem[r_rp[c_AW-1:0]];

  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_mem[r_wp[c_AW-1:0]] <= {req_x0, req_y0, req_w, req_h, req_colour};
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + c_PTR_ONE;
      if (w_pop)  r_rp <= r_rp + c_PTR_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Head-entry decode and clipping against the visible area
  // --------------------------------------------------------------------------
  logic [7:0]  w_hx0;
  logic [6:0]  w_hy0;
  logic [7:0]  w_hw;
  logic [6:0]  w_hh;
  logic [11:0] w_hcol;
  logic [8:0]  w_avail_w;
  logic [8:0]  w_eff_w;
  logic [8:0]  w_x_last;
  logic [7:0]  w_avail_h;
  logic [7:0]  w_eff_h;
  logic [7:0]  w_y_last;
  logic        w_drop;

  assign w_hx0  = w_head[41:34];
  assign w_hy0  = w_head[33:27];
  assign w_hw   = w_head[26:19];
  assign w_hh   = w_head[18:12];
  assign w_hcol = w_head[11:0];

  assign w_drop = (w_hw == 8'd0) || (w_hh == 7'd0) ||
                  ({1'b0, w_hx0} >= c_SCREEN_W) ||
                  ({1'b0, w_hy0} >= c_SCREEN_H);

  // Only meaningful when !w_drop, so the subtractions cannot underflow.
  assign w_avail_w = c_SCREEN_W - {1'b0, w_hx0};
  assign w_eff_w   = ({1'b0, w_hw} < w_avail_w) ? {1'b0, w_hw} : w_avail_w;
  assign w_x_last  = {1'b0, w_hx0} + w_eff_w - 9'd1;

  assign w_avail_h = c_SCREEN_H - {1'b0, w_hy0};
  assign w_eff_h   = ({1'b0, w_hh} < w_avail_h) ? {1'b0, w_hh} : w_avail_h;
  assign w_y_last  = {1'b0, w_hy0} + w_eff_h - 8'd1;

  // --------------------------------------------------------------------------
  // Draw datapath registers
  // --------------------------------------------------------------------------
  logic [8:0]  r_cx;
  logic [7:0]  r_cy;
  logic [8:0]  r_x_first;
  logic [8:0]  r_x_last;
  logic [7:0]  r_y_last;
  logic [11:0] r_fill;
  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic [11:0] r_colour;
  logic        r_we;

  logic [8:0]  w_cx_nxt;
  logic [7:0]  w_cy_nxt;
  logic [8:0]  w_xf_nxt;
  logic [8:0]  w_xl_nxt;
  logic [7:0]  w_yl_nxt;
  logic [11:0] w_fill_nxt;
  logic [7:0]  w_x_nxt;
  logic [6:0]  w_y_nxt;
  logic [11:0] w_col_nxt;
  logic        w_we_nxt;
  logic        w_row_end;
  logic        w_rect_end;

  assign w_row_end  = (r_cx == r_x_last);
  assign w_rect_end = w_row_end && (r_cy == r_y_last);

`ifdef CLEAR_ON_RESET_EN
  logic w_clr_done;
  // Leave CLEAR only once the final pixel has actually been presented.
  assign w_clr_done = r_we &&
                      ({1'b0, r_x} == (c_SCREEN_W - 9'd1)) &&
                      ({1'b0, r_y} == (c_SCREEN_H - 8'd1));
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
`ifdef CLEAR_ON_RESET_EN
      r_state <= S_CLEAR;
`else
      r_state <= S_IDLE;
`endif
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and next datapath/output values
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_we_nxt    = 1'b0;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_col_nxt   = r_colour;
    w_cx_nxt    = r_cx;
    w_cy_nxt    = r_cy;
    w_xf_nxt    = r_x_first;
    w_xl_nxt    = r_x_last;
    w_yl_nxt    = r_y_last;
    w_fill_nxt  = r_fill;

    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_nxt = S_LOAD;
      end

      S_LOAD: begin
        w_pop = 1'b1;
        if (w_drop) begin
          w_state_nxt = S_IDLE;
        end else begin
          // First pixel is registered here so it appears on the DRAW cycle.
          w_state_nxt = S_DRAW;
          w_cx_nxt    = {1'b0, w_hx0};
          w_cy_nxt    = {1'b0, w_hy0};
          w_xf_nxt    = {1'b0, w_hx0};
          w_xl_nxt    = w_x_last;
          w_yl_nxt    = w_y_last;
          w_fill_nxt  = w_hcol;
          w_we_nxt    = 1'b1;
          w_x_nxt     = w_hx0;
          w_y_nxt     = w_hy0;
          w_col_nxt   = w_hcol;
        end
      end

      S_DRAW: begin
        if (w_rect_end) begin
          w_state_nxt = w_empty ? S_IDLE : S_LOAD;
        end else begin
          if (w_row_end) begin
            w_cx_nxt = r_x_first;
            w_cy_nxt = r_cy + 8'd1;
          end else begin
            w_cx_nxt = r_cx + 9'd1;
          end
          w_we_nxt  = 1'b1;
          w_x_nxt   = w_cx_nxt[7:0];
          w_y_nxt   = w_cy_nxt[6:0];
          w_col_nxt = r_fill;
        end
      end

`ifdef CLEAR_ON_RESET_EN
      S_CLEAR: begin
        if (w_clr_done) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_we_nxt  = 1'b1;
          w_x_nxt   = r_cx[7:0];
          w_y_nxt   = r_cy[6:0];
          w_col_nxt = c_CLEAR_COLOUR;
          if (r_cx == (c_SCREEN_W - 9'd1)) begin
            w_cx_nxt = 9'd0;
            w_cy_nxt = (r_cy == (c_SCREEN_H - 8'd1)) ? 8'd0 : r_cy + 8'd1;
          end else begin
            w_cx_nxt = r_cx + 9'd1;
          end
        end
      end
`endif

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_cx      <= '0;
      r_cy      <= '0;
      r_x_first <= '0;
      r_x_last  <= '0;
      r_y_last  <= '0;
      r_fill    <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_colour  <= 12'h000;
      r_we      <= 1'b0;
    end else begin
      r_cx      <= w_cx_nxt;
      r_cy      <= w_cy_nxt;
      r_x_first <= w_xf_nxt;
      r_x_last  <= w_xl_nxt;
      r_y_last  <= w_yl_nxt;
      r_fill    <= w_fill_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_colour  <= w_col_nxt;
      r_we      <= w_we_nxt;
    end
  end

  assign x       = r_x;
  assign y       = r_y;
  assign colour  = r_colour;
  assign writeEn = r_we;
  assign busy    = !w_empty || (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_fill.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_rect_fill
// Brief    : Directed and randomized rectangle requests checked against a
//            pixel-list reference model built from the clipping rules.
// Revision : 1.0
// ============================================================================
module tb_vga_rect_fill;

  localparam int SW = 160;
  localparam int SH = 120;
`ifdef CLEAR_ON_RESET_EN
  localparam logic CLR = 1'b1;
`else
  localparam logic CLR = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  px;
    logic [6:0]  py;
    logic [11:0] pc;
  } pix_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_x0 = '0;
  logic [6:0]  req_y0 = '0;
  logic [7:0]  req_w = '0;
  logic [6:0]  req_h = '0;
  logic [11:0] req_colour = '0;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [11:0] colour;
  logic        writeEn;
  logic        busy;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   accepted = 0;
  logic full_seen = 1'b0;
  int   acc_at_full = 0;
  int   wr_at_full = 0;
  pix_t exp_q[$];
  pix_t obs_q[$];
  int   obs_cyc[$];

  vga_rect_fill #(
    .FIFO_DEPTH (4),
    .SCREEN_W   (SW),
    .SCREEN_H   (SH)
  ) u_dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x0     (req_x0),
    .req_y0     (req_y0),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .writeEn    (writeEn),
    .busy       (busy)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (writeEn === 1'b1) begin
      obs_q.push_back({x, y, colour});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge Clock);
    #1;
  endtask

  // Expected pixel list for one request, straight from the clipping rules.
  task automatic model_rect(input int x0, input int y0, input int w, input int h,
                            input logic [11:0] c);
    int ew;
    int eh;
    if (w == 0 || h == 0 || x0 >= SW || y0 >= SH) return;
    ew = (w < SW - x0) ? w : SW - x0;
    eh = (h < SH - y0) ? h : SH - y0;
    for (int yy = y0; yy < y0 + eh; yy++)
      for (int xx = x0; xx < x0 + ew; xx++)
        exp_q.push_back({8'(xx), 7'(yy), c});
  endtask

  task automatic send(input int x0, input int y0, input int w, input int h,
                      input logic [11:0] c, output int acc);
    logic rdy;
    req_x0     = 8'(x0);
    req_y0     = 7'(y0);
    req_w      = 8'(w);
    req_h      = 7'(h);
    req_colour = c;
    req_valid  = 1'b1;
    acc        = -1;
    for (int n = 0; n < 3000; n++) begin
      rdy = req_ready;
      if (!rdy && !full_seen) begin
        full_seen   = 1'b1;
        acc_at_full = accepted;
        wr_at_full  = obs_q.size();
      end
      step();
      if (rdy) begin
        acc = cyc;
        break;
      end
    end
    req_valid = 1'b0;
    if (acc < 0) begin
      check("send_timeout", 0, 1);
    end else begin
      accepted++;
      model_rect(x0, y0, w, h, c);
    end
  endtask

  task automatic wait_idle(input int bound, output int idle_c);
    idle_c = -1;
    for (int n = 0; n < bound; n++) begin
      if (!busy) begin
        idle_c = cyc;
        break;
      end
      step();
    end
    if (idle_c < 0) check("idle_timeout", 0, 1);
  endtask

  task automatic compare_stream(input string tag);
    int e0;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      e0 = n_err;
      check({tag, "_pix"}, obs_q[i], exp_q[i]);
      if (n_err != e0) break;
    end
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

`ifdef CLEAR_ON_RESET_EN
  task automatic clear_check();
    int bad_rdy;
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
    for (int yy = 0; yy < SH; yy++)
      for (int xx = 0; xx < SW; xx++)
        exp_q.push_back({8'(xx), 7'(yy), 12'h222});
    bad_rdy = 0;
    for (int n = 0; n < 20000 && busy; n++) begin
      if (req_ready) bad_rdy++;
      step();
    end
    check("clr_busy_end", busy, 0);
    check("clr_ready_during", bad_rdy, 0);
    check("clr_ready_after", req_ready, 1);
    compare_stream("clr");
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int idle_c;
    int bad;
    int d;
    int rw;

    repeat (3) step();
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 12'h000);
    check("rst_we", writeEn, 0);
    check("rst_busy", busy, CLR);
    check("rst_ready", req_ready, !CLR);
    Reset = 1'b0;
`ifdef CLEAR_ON_RESET_EN
    clear_check();
`else
    check("post_rst_ready", req_ready, 1);
`endif

    // Single request: latency, extent and busy fall.
    send(25, 21, 17, 7, 12'h2c3, acc);
    wait_idle(2000, idle_c);
    check("single_count", obs_q.size(), 119);
    if (obs_q.size() == 119) begin
      check("single_first_cyc", obs_cyc[0], acc + 2);
      check("single_first_pix", obs_q[0], {8'd25, 7'd21, 12'h2c3});
      check("single_last_pix", obs_q[118], {8'd41, 7'd27, 12'h2c3});
      check("single_span", obs_cyc[118] - obs_cyc[0], 118);
      check("single_busy_fall", idle_c, obs_cyc[118] + 1);
    end
    compare_stream("single");

    // Right-edge clip.
    send(150, 60, 20, 2, 12'h0f0, acc);
    wait_idle(200, idle_c);
    bad = 0;
    foreach (obs_q[i]) if (obs_q[i].px >= 8'(SW)) bad++;
    check("clip_x_range", bad, 0);
    compare_stream("clip");

    // Zero width: dropped quickly, no writes.
    send(30, 30, 0, 5, 12'hfff, acc);
    wait_idle(20, idle_c);
    check("zero_idle_lat", (idle_c - acc) <= 2, 1);
    repeat (5) step();
    check("zero_writes", obs_q.size(), 0);
    exp_q.delete();

    // Six back-to-back requests with valid held.
    full_seen = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 6; i++) send(8 + i * 24, 4 + i * 16, 16, 14, 12'h1f0 + 12'(i), acc);
    wait_idle(3000, idle_c);
    check("b2b_full_seen", full_seen, 1);
    check("b2b_full_occ", acc_at_full - (wr_at_full + 223) / 224, 4);
    bad = 0;
    for (int i = 1; i < obs_cyc.size(); i++) begin
      d = obs_cyc[i] - obs_cyc[i-1];
      if (d != ((i % 224 == 0) ? 2 : 1)) bad++;
    end
    check("b2b_gaps", bad, 0);
    compare_stream("b2b");

    // Randomized requests, occasionally very wide to exercise clipping.
    for (int i = 0; i < 24; i++) begin
      rw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 30));
      send($urandom_range(0, 175), $urandom_range(0, 127), rw, $urandom_range(0, 12),
           12'($urandom), acc);
      repeat ($urandom_range(0, 2)) step();
    end
    wait_idle(30000, idle_c);
    compare_stream("rnd");

    // Reset on the 50th pixel with a second request queued.
    send(25, 21, 17, 7, 12'h2c3, acc);
    send(40, 40, 10, 10, 12'h00f, acc);
    for (int n = 0; n < 400 && obs_q.size() < 50; n++) step();
    check("rst_mid_reached", obs_q.size(), 50);
    Reset = 1'b1;
    step();
    check("rst_mid_we", writeEn, 0);
    check("rst_mid_x", x, 0);
    check("rst_mid_busy", busy, CLR);
    Reset = 1'b0;
`ifdef CLEAR_ON_RESET_EN
    clear_check();
`else
    repeat (20) step();
    check("rst_mid_nowrites", obs_q.size(), 50);
    check("rst_mid_idle", busy, 0);
    check("rst_mid_ready", req_ready, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
